// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC generation, imem request/grant/response
// handshake and a prefetch FIFO of {pc, instr} feeding decode.
module fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             id_valid,
   input  logic             id_ready,
   output logic [31:0]      id_instr,
   output logic [WIDTH-1:0] id_pc
);
   localparam int          AW  = $clog2(DEPTH);
   localparam int          CW  = AW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

   logic [WIDTH-1:0] r_fetch_pc;
   logic [WIDTH-1:0] r_resp_pc;
   logic [31:0]      r_instr [DEPTH];
   logic [WIDTH-1:0] r_pc    [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    r_outst;
   logic [CW-1:0]    r_drop;

   logic             w_gnt;
   logic             w_rv;
   logic             w_push;
   logic             w_pop;
   logic             w_valid;
   logic [CW:0]      w_used;
   logic [WIDTH-1:0] w_target;

   // credit: buffered words plus words still in flight never exceed DEPTH
   assign w_used    = {1'b0, r_count} + {1'b0, r_outst};
   assign imem_req  = rst && !redirect && (w_used < CAP);
   assign imem_addr = r_fetch_pc;
   assign w_gnt     = imem_req && imem_gnt;
   assign w_rv      = imem_rvalid && (r_outst != '0);
   assign w_push    = w_rv && (r_drop == '0) && !redirect;
   assign w_valid   = (r_count != '0);
   assign w_pop     = w_valid && id_ready && !redirect;
   assign w_target  = redirect_pc & ~WIDTH'(3);

   assign id_valid = w_valid;
   assign id_instr = w_valid ? r_instr[r_rptr] : NOP;
   assign id_pc    = w_valid ? r_pc[r_rptr] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_outst    <= '0;
         r_drop     <= '0;
      end else if (redirect) begin
         // everything still in flight belongs to the old stream
         r_fetch_pc <= w_target;
         r_resp_pc  <= w_target;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_outst    <= r_outst - CW'(w_rv);
         r_drop     <= r_outst - CW'(w_rv);
      end else begin
         if (w_gnt) begin
            r_fetch_pc <= r_fetch_pc + WIDTH'(4);
         end
         if (w_push) begin
            r_resp_pc <= r_resp_pc + WIDTH'(4);
            r_wptr    <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         r_outst <= r_outst + CW'(w_gnt) - CW'(w_rv);
         if (w_rv && (r_drop != '0)) begin
            r_drop <= r_drop - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_instr[i] <= NOP;
            r_pc[i]    <= '0;
         end
      end else if (w_push) begin
         r_instr[r_wptr] <= imem_rdata;
         r_pc[r_wptr]    <= r_resp_pc;
      end
   end

   a_outst: assert property (@(posedge clk) disable iff (!rst)
      r_outst <= CW'(DEPTH));
   a_drop: assert property (@(posedge clk) disable iff (!rst)
      r_drop <= r_outst);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/decode traffic with an epoch-based
// reference model; a monitor checks every cycle against a scoreboard.
module tb_fetch_unit;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   fetch_unit #(
      .WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RPC)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_instr(id_instr), .id_pc(id_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          ep;
      logic [31:0] pc;
      int          due;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   pend_t       pend[$];
   exp_t        sb[$];
   int          vecs = 0;
   int          errs = 0;
   int          cyc = 0;
   int          epoch = 0;
   logic [31:0] mpc = RPC;
   int          p_gnt, p_rdy, p_redir, lat_max;
   bit          prev_wait = 0;
   bit          prev_redir = 0;
   logic [31:0] prev_addr = '0;
   int          first_gnt = -1;
   int          first_val = -1;
   bit          ev;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a ^ 32'h5A5A_5A5A) + {a[15:0], a[31:16]};
   endfunction

   function automatic logic [31:0] pick_tgt();
      case ($urandom_range(3))
         0: return $urandom;
         1: return 32'hFFFF_FFF0 + 32'($urandom_range(15));
         2: return 32'($urandom_range(1023));
         default: return 32'h0000_0100;
      endcase
   endfunction

   task automatic chk32(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b expected %b (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // monitor: compares the decode interface against the scoreboard
   always begin
      @(negedge clk);
      #1;
      if (rst === 1'b1) begin
         ev = (sb.size() != 0);
         chk1("id_valid", id_valid, ev);
         chk1("imem_req", imem_req,
              !redirect && ((sb.size() + pend.size()) < DEPTH));
         chk1("addr_align", |imem_addr[1:0], 1'b0);
         if (ev) begin
            chk32("id_pc", id_pc, sb[0].pc);
            chk32("id_instr", id_instr, sb[0].ins);
         end else begin
            chk32("idle_pc", id_pc, 32'h0);
            chk32("idle_instr", id_instr, NOP);
         end
         if (id_valid && first_val < 0) first_val = cyc;
         if (id_valid && id_ready && !redirect && ev)
            void'(sb.pop_front());
      end
   end

   // one clock of stimulus plus the reference model update for its edge
   task automatic cycle(input bit fr, input logic [31:0] ft);
      bit          rd;
      bit          rv;
      logic [31:0] tgt;
      logic        rq;
      logic [31:0] ad;
      pend_t       p;
      @(negedge clk);
      cyc++;
      rd = fr || (!prev_redir && ($urandom_range(99) < p_redir));
      tgt = fr ? ft : pick_tgt();
      redirect    = rd;
      redirect_pc = tgt;
      id_ready    = ($urandom_range(99) < p_rdy);
      imem_gnt    = ($urandom_range(99) < p_gnt);
      rv = (pend.size() != 0) && (pend[0].due <= cyc);
      imem_rvalid = rv;
      imem_rdata  = rv ? pend[0].data : $urandom;
      #2;
      rq = imem_req;
      ad = imem_addr;
      if (prev_wait) chk32("addr_hold", ad, prev_addr);
      prev_wait  = rq && !imem_gnt;
      prev_addr  = ad;
      prev_redir = rd;
      if (rd) begin
         epoch++;
         mpc = tgt & ~32'h3;
         sb.delete();
      end
      if (rv) begin
         p = pend.pop_front();
         if (p.ep == epoch) sb.push_back('{p.pc, memf(p.pc)});
      end
      if (rq && imem_gnt) begin
         if (first_gnt < 0) first_gnt = cyc;
         pend.push_back('{memf(ad), epoch, mpc,
                          cyc + 1 + int'($urandom_range(lat_max))});
         mpc += 32'h4;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3;
      redirect    = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      id_ready    = 1'b0;
      rst         = 1'b0;
      #1;
      chk1("rst_req", imem_req, 1'b0);
      chk32("rst_addr", imem_addr, RPC);
      chk1("rst_valid", id_valid, 1'b0);
      chk32("rst_instr", id_instr, NOP);
      chk32("rst_pc", id_pc, 32'h0);
      pend.delete();
      sb.delete();
      epoch++;
      mpc        = RPC;
      prev_wait  = 1'b0;
      prev_redir = 1'b0;
      repeat (2) @(negedge clk);
      #3 rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      id_ready = 1'b0;
      p_gnt = 100; p_rdy = 100; p_redir = 0; lat_max = 0;
      do_reset();

      // streaming with zero-wait memory
      run(30);
      chk32("grant_to_valid", 32'(first_val - first_gnt), 32'd2);

      // decode stalled: FIFO fills, requests stop, then drains in order
      p_rdy = 0;
      run(12);
      p_rdy = 100;
      run(12);

      // grant withheld: address must hold
      p_gnt = 0;
      run(5);
      p_gnt = 100;
      run(6);

      // redirect with responses in flight and words buffered
      p_rdy = 0; lat_max = 2;
      run(4);
      cycle(1'b1, 32'h0000_0100);
      p_rdy = 100;
      run(12);

      // back-to-back-ish redirects, unaligned target, PC wrap
      lat_max = 0;
      cycle(1'b1, 32'h0000_0180);
      cycle(1'b0, 32'h0);
      cycle(1'b1, 32'h0000_0200);
      run(10);
      cycle(1'b1, 32'h0000_0103);
      run(8);
      cycle(1'b1, 32'hFFFF_FFF8);
      run(10);

      // randomized traffic with a mid-stream reset
      p_gnt = 70; p_rdy = 60; p_redir = 5; lat_max = 3;
      run(1500);
      do_reset();
      run(1500);

      p_gnt = 100; p_rdy = 100; p_redir = 0; lat_max = 0;
      run(30);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
